// File: rtl/display_mode_ctrl.sv
// Frame-synchronous mode controller for the pixel output mux.
// Button, direct-select and auto-cycle requests commit only on new_frame_in.
module display_mode_ctrl #(
   parameter int         DEBOUNCE_CYCLES = 1_000_000,
   parameter int         AUTO_FRAMES     = 120,
   parameter logic [1:0] RESET_MODE      = 2'd0
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       btn_in,
   input  logic       sel_valid_in,
   input  logic [1:0] sel_mode_in,
   input  logic       auto_in,
   input  logic       new_frame_in,
   output logic [1:0] mode_out,
   output logic       bg_out,
   output logic       target_out,
   output logic       mode_changed_out
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic            btn_sync;
   logic            stable_q;
   logic [DW-1:0]   db_cnt_q;
   logic            db_mismatch, db_flip, press;
   logic [AW-1:0]   auto_cnt_q;
   logic            auto_hit;
   logic            adv_pend_q, sel_pend_q;
   logic [1:0]      sel_reg_q;
   logic [1:0]      mode_q, mode_nxt;
   logic            changed_q;
   logic            commit;
   logic            request;

   assign btn_sync    = sync_q[1];
   assign db_mismatch = btn_sync != stable_q;
   assign db_flip     = db_mismatch && (db_cnt_q == DB_LAST);
   assign press       = db_flip && btn_sync;
   assign auto_hit    = auto_in && new_frame_in && (auto_cnt_q == AUTO_LAST);
   assign request     = press || sel_valid_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_q   <= 2'b00;
         stable_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_in};
         if (!db_mismatch || db_flip)
            db_cnt_q <= '0;
         else
            db_cnt_q <= db_cnt_q + 1'b1;
         if (db_flip)
            stable_q <= btn_sync;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (request)
               state_d = PENDING;
         end
         PENDING: begin
            if (commit && !request)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Priority: direct select, then button advance, then auto step.
   always_comb begin
      commit   = 1'b0;
      mode_nxt = mode_q;
      if (new_frame_in && state_q == PENDING && sel_pend_q) begin
         commit   = 1'b1;
         mode_nxt = sel_reg_q;
      end else if (new_frame_in && state_q == PENDING && adv_pend_q) begin
         commit   = 1'b1;
         mode_nxt = mode_q + 2'd1;
      end else if (auto_hit) begin
         commit   = 1'b1;
         mode_nxt = mode_q + 2'd1;
      end
   end

   // Requests arriving on a boundary survive the clear and wait one frame.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         adv_pend_q <= 1'b0;
         sel_pend_q <= 1'b0;
         sel_reg_q  <= 2'd0;
      end else begin
         if (press)
            adv_pend_q <= 1'b1;
         else if (commit)
            adv_pend_q <= 1'b0;
         if (sel_valid_in)
            sel_pend_q <= 1'b1;
         else if (commit)
            sel_pend_q <= 1'b0;
         if (sel_valid_in)
            sel_reg_q <= sel_mode_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         auto_cnt_q <= '0;
      else if (!auto_in)
         auto_cnt_q <= '0;
      else if (new_frame_in) begin
         if (auto_hit || commit)
            auto_cnt_q <= '0;
         else
            auto_cnt_q <= auto_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode_q    <= RESET_MODE;
         changed_q <= 1'b0;
      end else begin
         changed_q <= commit && (mode_nxt != mode_q);
         if (commit)
            mode_q <= mode_nxt;
      end
   end

   assign mode_out         = mode_q;
   assign bg_out           = mode_q[0];
   assign target_out       = mode_q[1];
   assign mode_changed_out = changed_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed scenarios plus a randomized run
// against a request/commit reference model.
module tb_display_mode_ctrl;

   localparam int DB = 4;
   localparam int AF = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic       sv = 1'b0;
   logic [1:0] sm = 2'd0;
   logic       auto_en = 1'b0;
   logic       nf = 1'b0;
   logic [1:0] mode_out;
   logic       bg_out, target_out, mode_changed_out;

   int n_checks = 0;
   int n_fail = 0;

   display_mode_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .AUTO_FRAMES(AF),
      .RESET_MODE(2'd0)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .btn_in(btn),
      .sel_valid_in(sv),
      .sel_mode_in(sm),
      .auto_in(auto_en),
      .new_frame_in(nf),
      .mode_out(mode_out),
      .bg_out(bg_out),
      .target_out(target_out),
      .mode_changed_out(mode_changed_out)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frame;
      nf = 1'b1;
      tick();
      nf = 1'b0;
   endtask

   task automatic do_sel(input logic [1:0] m);
      sv = 1'b1;
      sm = m;
      tick();
      sv = 1'b0;
   endtask

   task automatic press_btn;
      btn = 1'b1;
      repeat (8) tick();
      btn = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      n_checks++;
      if (mode_out !== 2'd0 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: mode=%0d chg=%0d expected 0/0",
                  mode_out, mode_changed_out);
      end
      do_sel(2'd2);
      frame();
      n_checks++;
      if (mode_out !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_setup: mode=%0d expected 2", mode_out);
      end
      btn = 1'b1;
      repeat (7) tick();
      btn = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (mode_out !== 2'd0 || bg_out !== 1'b0 || target_out !== 1'b0
          || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: mode=%0d bg=%0d tg=%0d chg=%0d expected 0",
                  mode_out, bg_out, target_out, mode_changed_out);
      end
      rst = 1'b0;
      repeat (3) tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd0 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_discard: mode=%0d chg=%0d expected 0/0",
                  mode_out, mode_changed_out);
      end
      repeat (8) tick();
   endtask

   task automatic test_button;
      btn = 1'b1;
      repeat (10) tick();
      btn = 1'b0;
      n_checks++;
      if (mode_out !== 2'd0) begin
         n_fail++;
         $display("FAIL btn_precommit: mode=%0d expected 0", mode_out);
      end
      frame();
      n_checks++;
      if (mode_out !== 2'd1 || bg_out !== 1'b1 || target_out !== 1'b0
          || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL btn_commit: mode=%0d bg=%0d tg=%0d chg=%0d expected 1/1/0/1",
                  mode_out, bg_out, target_out, mode_changed_out);
      end
      tick();
      n_checks++;
      if (mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL btn_pulse_width: chg=%0d expected 0", mode_changed_out);
      end
      repeat (10) tick();
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      repeat (10) tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd1 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL btn_glitch: mode=%0d chg=%0d expected 1/0",
                  mode_out, mode_changed_out);
      end
   endtask

   task automatic test_multi_press;
      press_btn();
      press_btn();
      press_btn();
      frame();
      n_checks++;
      if (mode_out !== 2'd2 || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_press: mode=%0d chg=%0d expected 2/1",
                  mode_out, mode_changed_out);
      end
      tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd2 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_press_once: mode=%0d chg=%0d expected 2/0",
                  mode_out, mode_changed_out);
      end
      // press qualifies on the 6th edge after btn rises; frame hits that edge
      btn = 1'b1;
      repeat (5) tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd2 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle_press: mode=%0d chg=%0d expected 2/0",
                  mode_out, mode_changed_out);
      end
      btn = 1'b0;
      repeat (3) tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd3 || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL same_cycle_next: mode=%0d chg=%0d expected 3/1",
                  mode_out, mode_changed_out);
      end
      repeat (8) tick();
   endtask

   task automatic test_sel_override;
      press_btn();
      do_sel(2'd3);
      do_sel(2'd2);
      frame();
      n_checks++;
      if (mode_out !== 2'd2 || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL sel_last_wins: mode=%0d chg=%0d expected 2/1",
                  mode_out, mode_changed_out);
      end
      tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd2 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL sel_consumed: mode=%0d chg=%0d expected 2/0",
                  mode_out, mode_changed_out);
      end
   endtask

   task automatic test_auto;
      do_sel(2'd3);
      frame();
      auto_en = 1'b1;
      tick();
      frame();
      tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd3) begin
         n_fail++;
         $display("FAIL auto_early: mode=%0d expected 3", mode_out);
      end
      tick();
      frame();
      n_checks++;
      if (mode_out !== 2'd0 || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_wrap: mode=%0d chg=%0d expected 0/1",
                  mode_out, mode_changed_out);
      end
      frame();
      frame();
      auto_en = 1'b0;
      tick();
      auto_en = 1'b1;
      frame();
      frame();
      n_checks++;
      if (mode_out !== 2'd0) begin
         n_fail++;
         $display("FAIL auto_drop_clear: mode=%0d expected 0", mode_out);
      end
      frame();
      n_checks++;
      if (mode_out !== 2'd1 || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_restart: mode=%0d chg=%0d expected 1/1",
                  mode_out, mode_changed_out);
      end
      auto_en = 1'b0;
      tick();
   endtask

   task automatic test_sel_same;
      do_sel(2'd1);
      frame();
      n_checks++;
      if (mode_out !== 2'd1 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL sel_same: mode=%0d chg=%0d expected 1/0",
                  mode_out, mode_changed_out);
      end
      frame();
      n_checks++;
      if (mode_out !== 2'd1 || mode_changed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL sel_same_idle: mode=%0d chg=%0d expected 1/0",
                  mode_out, mode_changed_out);
      end
      press_btn();
      frame();
      n_checks++;
      if (mode_out !== 2'd2 || mode_changed_out !== 1'b1) begin
         n_fail++;
         $display("FAIL sel_same_after: mode=%0d chg=%0d expected 2/1",
                  mode_out, mode_changed_out);
      end
   endtask

   task automatic test_random;
      logic [1:0] m_mode, m_sel, nm;
      logic       m_sp, m_ap, m_chg, commit, hit, press;
      int         m_acnt, hi, burst;
      auto_en = 1'b0;
      btn = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      m_mode = 2'd0;
      m_sel = 2'd0;
      m_sp = 1'b0;
      m_ap = 1'b0;
      m_acnt = 0;
      hi = 0;
      burst = 0;
      for (int c = 0; c < 1500; c++) begin
         nf = ($urandom_range(3) == 0);
         sv = ($urandom_range(7) == 0);
         sm = 2'($urandom_range(3));
         if ($urandom_range(39) == 0)
            auto_en = ~auto_en;
         if (burst == 0 && $urandom_range(20) == 0)
            burst = 16;
         btn = (burst > 8);
         if (burst > 0)
            burst--;
         tick();
         // press is seen on the edge completing 2 sync + DB stable cycles
         hi = btn ? hi + 1 : 0;
         press = (hi == 2 + DB);
         hit = auto_en && nf && (m_acnt == AF - 1);
         commit = 1'b0;
         nm = m_mode;
         if (nf && m_sp) begin
            commit = 1'b1;
            nm = m_sel;
         end else if (nf && m_ap) begin
            commit = 1'b1;
            nm = m_mode + 2'd1;
         end else if (hit) begin
            commit = 1'b1;
            nm = m_mode + 2'd1;
         end
         m_chg = commit && (nm != m_mode);
         m_mode = nm;
         if (!auto_en)
            m_acnt = 0;
         else if (nf)
            m_acnt = (hit || commit) ? 0 : m_acnt + 1;
         if (commit) begin
            m_sp = 1'b0;
            m_ap = 1'b0;
         end
         if (press)
            m_ap = 1'b1;
         if (sv) begin
            m_sp = 1'b1;
            m_sel = sm;
         end
         n_checks++;
         if (mode_out !== m_mode || bg_out !== m_mode[0]
             || target_out !== m_mode[1] || mode_changed_out !== m_chg) begin
            n_fail++;
            $display("FAIL random c=%0d: mode=%0d bg=%0d tg=%0d chg=%0d expected mode=%0d chg=%0d",
                     c, mode_out, bg_out, target_out, mode_changed_out,
                     m_mode, m_chg);
         end
      end
      nf = 1'b0;
      sv = 1'b0;
      btn = 1'b0;
      auto_en = 1'b0;
   endtask

   initial begin
      #12;
      rst = 1'b0;
      test_reset();
      test_button();
      test_multi_press();
      test_sel_override();
      test_auto();
      test_sel_same();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
